// File: rtl/ising_machine_seq.sv
// Time-multiplexed oscillator Ising machine: N phase lanes share one coupling MAC,
// Jacobi phase updates with a ramped second-harmonic (SHIL) term for binarisation.

module ising_osc_lane #(
  parameter int PHASE_W = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               init_we,
  input  logic [PHASE_W-1:0] init_phase,
  input  logic               upd_we,
  input  logic [PHASE_W-1:0] upd_phase,
  input  logic               commit,
  output logic [PHASE_W-1:0] phase,
  output logic               spin
);
  logic [PHASE_W-1:0] shadow;

  always_ff @(posedge clk) begin
    if (rst) begin
      phase  <= '0;
      shadow <= '0;
    end else begin
      if (init_we)     phase <= init_phase;
      else if (commit) phase <= shadow;
      if (upd_we)      shadow <= upd_phase;
    end
  end

  assign spin = phase[PHASE_W-1] ^ phase[PHASE_W-2];
endmodule

module ising_machine_seq #(
  parameter int N         = 16,
  parameter int DATA_W    = 32,
  parameter int FRAC_BITS = 16,
  parameter int PHASE_W   = 16,
  parameter int SHIFT     = 20
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 cfg_we,
  input  logic [$clog2(N)-1:0] cfg_i,
  input  logic [$clog2(N)-1:0] cfg_j,
  input  logic [DATA_W-1:0]    cfg_wdata,
  input  logic                 init_we,
  input  logic [$clog2(N)-1:0] init_addr,
  input  logic [PHASE_W-1:0]   init_phase,
  input  logic                 start,
  input  logic [DATA_W-1:0]    num_steps,
  input  logic [DATA_W-1:0]    delta_t,
  input  logic [DATA_W-1:0]    ks_inc,
  input  logic [DATA_W-1:0]    ks_max,
  input  logic [$clog2(N)-1:0] rd_addr,
  output logic [PHASE_W-1:0]   rd_phase,
  output logic [N-1:0]         spins,
  output logic                 busy,
  output logic                 done
);
  localparam int AW      = $clog2(N);
  localparam int SW      = DATA_W + PHASE_W + AW + 1;
  localparam int PW_PROD = SHIFT + PHASE_W;
  localparam logic signed [PHASE_W:0] QTR  = (PHASE_W+1)'(1) <<< (PHASE_W-2);
  localparam logic signed [PHASE_W:0] HALF = (PHASE_W+1)'(1) <<< (PHASE_W-1);

  if (N < 2 || FRAC_BITS >= DATA_W || SHIFT < 1) begin : g_bad_params
    $error("ising_machine_seq: unsupported parameter set");
  end

  typedef struct packed {
    logic        [DATA_W-1:0] num_steps;
    logic signed [DATA_W-1:0] delta_t;
    logic signed [DATA_W-1:0] ks_inc;
    logic signed [DATA_W-1:0] ks_max;
  } run_cfg_t;

  typedef enum logic [2:0] {S_IDLE, S_ACCUM, S_UPDATE, S_COMMIT, S_DONE} state_t;

  // Triangle approximation of sin over one turn; 1.0 maps to a quarter turn.
  function automatic logic signed [PHASE_W:0] tri_wave(input logic [PHASE_W-1:0] d);
    logic signed [PHASE_W:0] s;
    s = {d[PHASE_W-1], d};
    if (s > QTR)       return HALF - s;
    else if (s < -QTR) return -HALF - s;
    else               return s;
  endfunction

  state_t                      state, state_nxt;
  run_cfg_t                    cfg;
  logic signed [DATA_W-1:0]    jmem [N][N];
  logic signed [DATA_W-1:0]    ks, ks_nxt;
  logic signed [DATA_W:0]      ks_sum, ks_max_ext;
  logic signed [SW-1:0]        s_acc, mac_term, shil, s_upd;
  logic signed [PW_PROD-1:0]   upd_prod;
  logic [AW-1:0]               i_cnt, j_cnt;
  logic [DATA_W-1:0]           step_cnt, step_nxt;
  logic [N-1:0][PHASE_W-1:0]   ph_all;
  logic [PHASE_W-1:0]          ph_i, ph_j, d_ji, ph_i2, upd_phase;
  logic                        unused_bits;

  // J memory has no reset so it maps onto RAM.
  always_ff @(posedge clk) begin
    if (state == S_IDLE && cfg_we) jmem[cfg_i][cfg_j] <= cfg_wdata;
  end

  for (genvar g = 0; g < N; g++) begin : g_lane
    ising_osc_lane #(.PHASE_W(PHASE_W)) u_lane (
      .clk       (clk),
      .rst       (rst),
      .init_we   (state == S_IDLE && init_we && init_addr == AW'(g)),
      .init_phase(init_phase),
      .upd_we    (state == S_UPDATE && i_cnt == AW'(g)),
      .upd_phase (upd_phase),
      .commit    (state == S_COMMIT),
      .phase     (ph_all[g]),
      .spin      (spins[g])
    );
  end

  always_comb begin
    ph_i      = ph_all[i_cnt];
    ph_j      = ph_all[j_cnt];
    d_ji      = ph_j - ph_i;
    ph_i2     = {ph_i[PHASE_W-2:0], 1'b0};
    mac_term  = SW'(jmem[i_cnt][j_cnt]) * SW'(tri_wave(d_ji));
    shil      = SW'(ks) * SW'(tri_wave(ph_i2));
    s_upd     = s_acc - shil;
    // Only bits [SHIFT +: PHASE_W] of the product survive, so a narrow multiply suffices.
    upd_prod  = PW_PROD'(s_upd) * PW_PROD'(cfg.delta_t);
    upd_phase = ph_i + upd_prod[PW_PROD-1:SHIFT];
    ks_sum     = {ks[DATA_W-1], ks} + {cfg.ks_inc[DATA_W-1], cfg.ks_inc};
    ks_max_ext = {cfg.ks_max[DATA_W-1], cfg.ks_max};
    ks_nxt     = (ks_sum > ks_max_ext) ? cfg.ks_max : ks_sum[DATA_W-1:0];
    step_nxt   = step_cnt + DATA_W'(1);
  end

  assign unused_bits = ^upd_prod[SHIFT-1:0];

  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:   if (start) state_nxt = (num_steps == '0) ? S_DONE : S_ACCUM;
      S_ACCUM:  if (j_cnt == AW'(N-1)) state_nxt = S_UPDATE;
      S_UPDATE: state_nxt = (i_cnt == AW'(N-1)) ? S_COMMIT : S_ACCUM;
      S_COMMIT: state_nxt = (step_nxt == cfg.num_steps) ? S_DONE : S_ACCUM;
      S_DONE:   state_nxt = S_IDLE;
      default:  state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    busy = (state == S_ACCUM) || (state == S_UPDATE) || (state == S_COMMIT);
    done = (state == S_DONE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cfg      <= '0;
      ks       <= '0;
      s_acc    <= '0;
      i_cnt    <= '0;
      j_cnt    <= '0;
      step_cnt <= '0;
    end else begin
      case (state)
        S_IDLE: if (start) begin
          cfg      <= '{num_steps, delta_t, ks_inc, ks_max};
          ks       <= '0;
          s_acc    <= '0;
          i_cnt    <= '0;
          j_cnt    <= '0;
          step_cnt <= '0;
        end
        S_ACCUM: begin
          s_acc <= s_acc + mac_term;
          j_cnt <= (j_cnt == AW'(N-1)) ? '0 : j_cnt + AW'(1);
        end
        S_UPDATE: begin
          s_acc <= '0;
          i_cnt <= (i_cnt == AW'(N-1)) ? '0 : i_cnt + AW'(1);
        end
        S_COMMIT: begin
          ks       <= ks_nxt;
          step_cnt <= step_nxt;
          i_cnt    <= '0;
        end
        default: ;
      endcase
    end
  end

  assign rd_phase = ph_all[rd_addr];
endmodule

// File: tb/tb_ising_machine_seq.sv
// Directed bench for ising_machine_seq with N=4: hand-computed phases, latency,
// busy-time protection, mid-run reset and SHIL binarisation of an antiferro ring.

module tb_ising_machine_seq;
  localparam int N  = 4;
  localparam int DW = 32;
  localparam int PW = 16;
  localparam int AW = 2;
  localparam logic [DW-1:0] JP1 = 32'h0001_0000;
  localparam logic [DW-1:0] JM1 = 32'hFFFF_0000;

  logic          clk = 1'b0;
  logic          rst;
  logic          cfg_we;
  logic [AW-1:0] cfg_i, cfg_j, init_addr, rd_addr;
  logic [DW-1:0] cfg_wdata, num_steps, delta_t, ks_inc, ks_max;
  logic          init_we, start;
  logic [PW-1:0] init_phase, rd_phase;
  logic [N-1:0]  spins;
  logic          busy, done;

  int n_vec = 0;
  int n_err = 0;
  int lat, nd, cnt;
  logic b1;

  ising_machine_seq #(.N(N), .DATA_W(DW), .FRAC_BITS(16), .PHASE_W(PW), .SHIFT(20)) dut (
    .clk(clk), .rst(rst), .cfg_we(cfg_we), .cfg_i(cfg_i), .cfg_j(cfg_j),
    .cfg_wdata(cfg_wdata), .init_we(init_we), .init_addr(init_addr),
    .init_phase(init_phase), .start(start), .num_steps(num_steps),
    .delta_t(delta_t), .ks_inc(ks_inc), .ks_max(ks_max), .rd_addr(rd_addr),
    .rd_phase(rd_phase), .spins(spins), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic wr_j(input int i, input int j, input logic [DW-1:0] v);
    cfg_we = 1'b1; cfg_i = AW'(i); cfg_j = AW'(j); cfg_wdata = v;
    tick();
    cfg_we = 1'b0;
  endtask

  task automatic wr_ph(input int a, input logic [PW-1:0] v);
    init_we = 1'b1; init_addr = AW'(a); init_phase = v;
    tick();
    init_we = 1'b0;
  endtask

  task automatic chk_ph(input string tag, input int a, input logic [PW-1:0] v);
    rd_addr = AW'(a);
    #1;
    chk($sformatf("%s_ph%0d", tag, a), 32'(rd_phase), 32'(v));
  endtask

  // Start a run; lat = cycle (1 = first cycle after the start edge) of the first done.
  task automatic run(input logic [DW-1:0] steps, input logic [DW-1:0] dt,
                     input logic [DW-1:0] inc, input logic [DW-1:0] kmax,
                     input bit poke, input int bound,
                     output int lat_o, output int nd_o, output logic busy1);
    num_steps = steps; delta_t = dt; ks_inc = inc; ks_max = kmax;
    start = 1'b1;
    tick();
    start = 1'b0;
    lat_o = 0; nd_o = 0; busy1 = busy;
    for (int c = 1; c <= bound; c++) begin
      if (done) begin
        nd_o++;
        if (lat_o == 0) lat_o = c;
      end
      if (lat_o != 0 && c >= lat_o + 3) break;
      if (poke && c == 1) begin
        start = 1'b1;
        cfg_we = 1'b1; cfg_i = 2'd0; cfg_j = 2'd1; cfg_wdata = JP1;
        init_we = 1'b1; init_addr = 2'd0; init_phase = 16'h1234;
      end
      tick();
      start = 1'b0; cfg_we = 1'b0; init_we = 1'b0;
    end
  endtask

  initial begin
    rst = 1'b1; cfg_we = 1'b0; cfg_i = '0; cfg_j = '0; cfg_wdata = '0;
    init_we = 1'b0; init_addr = '0; init_phase = '0; start = 1'b0;
    num_steps = '0; delta_t = '0; ks_inc = '0; ks_max = '0; rd_addr = '0;

    // Reset state
    repeat (2) tick();
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_spins", 32'(spins), 32'd0);
    for (int a = 0; a < N; a++) chk_ph("rst", a, 16'h0000);
    rst = 1'b0;
    tick();

    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++) wr_j(i, j, '0);

    // Anti-coupled pair, one step
    wr_j(0, 1, JM1); wr_j(1, 0, JM1);
    wr_ph(0, 16'h0000); wr_ph(1, 16'h4000);
    run(1, 1, 0, 0, 1'b0, 200, lat, nd, b1);
    chk("pair_lat", 32'(lat), 32'd22);
    chk("pair_busy1", 32'(b1), 32'd1);
    chk("pair_ndone", 32'(nd), 32'd1);
    chk_ph("pair", 0, 16'hFC00);
    chk_ph("pair", 1, 16'h4400);
    chk_ph("pair", 2, 16'h0000);
    chk_ph("pair", 3, 16'h0000);
    chk("pair_spins", 32'(spins), 32'h2);

    // Writes and start while busy are ignored
    wr_ph(0, 16'h0000); wr_ph(1, 16'h4000);
    run(1, 1, 0, 0, 1'b1, 200, lat, nd, b1);
    chk("busy_lat", 32'(lat), 32'd22);
    chk("busy_ndone", 32'(nd), 32'd1);
    chk_ph("busy", 0, 16'hFC00);
    chk_ph("busy", 1, 16'h4400);
    wr_ph(0, 16'h0000); wr_ph(1, 16'h4000);
    run(1, 1, 0, 0, 1'b0, 200, lat, nd, b1);
    chk_ph("jkeep", 0, 16'hFC00);
    chk_ph("jkeep", 1, 16'h4400);

    // Zero-step run
    run(0, 1, 0, 0, 1'b0, 50, lat, nd, b1);
    chk("zero_lat", 32'(lat), 32'd1);
    chk("zero_ndone", 32'(nd), 32'd1);
    chk_ph("zero", 0, 16'hFC00);

    // Wrap through zero
    wr_j(0, 1, JP1); wr_j(1, 0, JP1);
    wr_ph(0, 16'hFFF0); wr_ph(1, 16'h3FF0);
    run(1, 1, 0, 0, 1'b0, 200, lat, nd, b1);
    chk("wrap_lat", 32'(lat), 32'd22);
    chk_ph("wrap", 0, 16'h03F0);
    chk_ph("wrap", 1, 16'h3BF0);

    // Reset in the middle of ACCUM
    wr_ph(0, 16'hFFF0); wr_ph(1, 16'h3FF0);
    num_steps = 32'd1; delta_t = 32'd1; ks_inc = '0; ks_max = '0;
    start = 1'b1;
    tick();
    start = 1'b0;
    tick(); tick();
    chk("mid_busy_pre", 32'(busy), 32'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("mid_busy", 32'(busy), 32'd0);
    chk("mid_done", 32'(done), 32'd0);
    chk("mid_spins", 32'(spins), 32'd0);
    chk_ph("mid", 0, 16'h0000);
    chk_ph("mid", 1, 16'h0000);
    cnt = 0;
    for (int c = 0; c < 30; c++) begin
      if (done) cnt++;
      tick();
    end
    chk("mid_nodone", 32'(cnt), 32'd0);
    wr_ph(0, 16'hFFF0); wr_ph(1, 16'h3FF0);
    run(1, 1, 0, 0, 1'b0, 200, lat, nd, b1);
    chk("rerun_lat", 32'(lat), 32'd22);
    chk_ph("rerun", 0, 16'h03F0);
    chk_ph("rerun", 1, 16'h3BF0);

    // Antiferro ring, SHIL ramp locks pairs at 0 and half a turn
    wr_j(0, 1, JM1); wr_j(1, 0, JM1); wr_j(1, 2, JM1); wr_j(2, 1, JM1);
    wr_j(2, 3, JM1); wr_j(3, 2, JM1); wr_j(3, 0, JM1); wr_j(0, 3, JM1);
    wr_ph(0, 16'h1000); wr_ph(1, 16'h9000); wr_ph(2, 16'h1000); wr_ph(3, 16'h9000);
    run(400, 1, 32'h100, 32'h10000, 1'b0, 9000, lat, nd, b1);
    chk("ring_lat", 32'(lat), 32'd8401);
    chk("ring_spins", 32'(spins), 32'hA);
    chk_ph("ring", 0, 16'h0000);
    chk_ph("ring", 1, 16'h8000);
    chk_ph("ring", 2, 16'h0000);
    chk_ph("ring", 3, 16'h8000);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
